// File: rtl/maze_input_pkg.sv
// Shared types, bit positions and helpers for the maze input conditioning stage.
package maze_input_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } coin_state_t;

  // gdb0 bit positions
  localparam int unsigned GDB0_LEFT1  = 0;
  localparam int unsigned GDB0_RIGHT1 = 1;
  localparam int unsigned GDB0_DOWN1  = 2;
  localparam int unsigned GDB0_UP1    = 3;
  localparam int unsigned GDB0_LEFT2  = 4;
  localparam int unsigned GDB0_RIGHT2 = 5;
  localparam int unsigned GDB0_DOWN2  = 6;
  localparam int unsigned GDB0_UP2    = 7;

  // gdb1 bit positions
  localparam int unsigned GDB1_START1 = 0;
  localparam int unsigned GDB1_START2 = 1;
  localparam int unsigned GDB1_COIN   = 3;

  localparam logic [1:0] PENDING_MAX = 2'd3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Clears both members of an opposing pair; dir is {up,down,right,left}.
  function automatic logic [3:0] suppress_dir(input logic [3:0] dir);
    logic [3:0] res;
    res = dir;
    if (dir[3] && dir[2]) res[3:2] = 2'b00;
    if (dir[1] && dir[0]) res[1:0] = 2'b00;
    return res;
  endfunction

endpackage

// File: rtl/input_debounce.sv
// Single-bit debouncer: a raw change must persist for DEB_CYCLES consecutive edges.
module input_debounce #(
  parameter int unsigned DEB_CYCLES = 20000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stable_q, stable_d;
  logic            rise_q, rise_d;

  // Count consecutive mismatches; adopt raw on the last one.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    if (raw == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      stable_d = raw;
      cnt_d    = '0;
      rise_d   = raw;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
    end
  end

  assign stable = stable_q;
  // High for the single cycle in which stable has just become 1.
  assign rise   = rise_q;

endmodule

// File: rtl/maze_input_cond.sv
// Input conditioning for the maze game core: debounce, opposing-direction
// suppression, and rate-limited coin pulses with a small credit queue.
module maze_input_cond
  import maze_input_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 20000,
  parameter int unsigned COIN_PULSE = 100000,
  parameter int unsigned COIN_GAP   = 100000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [3:0] p1_dir,
  input  logic [3:0] p2_dir,
  input  logic       coin_raw,
  input  logic       start1_raw,
  input  logic       start2_raw,
  output logic [7:0] gdb0,
  output logic [7:0] gdb1,
  output logic [1:0] coin_pending
);

  localparam int unsigned NumBits   = 11;
  localparam int unsigned RawCoin   = 8;
  localparam int unsigned RawStart1 = 9;
  localparam int unsigned RawStart2 = 10;
  localparam int unsigned TimerW    = $clog2(max_u(COIN_PULSE, COIN_GAP) + 1);
  localparam logic [TimerW-1:0] PulseLast = TimerW'(COIN_PULSE - 1);
  localparam logic [TimerW-1:0] GapLast   = TimerW'(COIN_GAP - 1);

  logic [NumBits-1:0] raw_vec, stable_vec, rise_vec;
  logic               unused_rise;

  assign raw_vec = {start2_raw, start1_raw, coin_raw, p2_dir, p1_dir};

  for (genvar i = 0; i < NumBits; i++) begin : g_deb
    input_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk_sys(clk_sys),
      .reset  (reset),
      .raw    (raw_vec[i]),
      .stable (stable_vec[i]),
      .rise   (rise_vec[i])
    );
  end

  // Only the coin debouncer's rising edge is consumed.
  assign unused_rise = ^{rise_vec[RawStart2:RawStart1], rise_vec[RawCoin-1:0]};

  logic [7:0]        gdb0_q, gdb0_d;
  logic [1:0]        start_q, start_d;
  coin_state_t       state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [1:0]        pending_q, pending_d;
  logic              take;
  logic              coin_rise;

  assign coin_rise = rise_vec[RawCoin];

  // Player bytes and start bits registered from suppressed debounced state.
  always_comb begin
    logic [3:0] p1_s, p2_s;
    p1_s   = suppress_dir(stable_vec[3:0]);
    p2_s   = suppress_dir(stable_vec[7:4]);
    gdb0_d = '0;
    gdb0_d[GDB0_LEFT1]  = p1_s[0];
    gdb0_d[GDB0_RIGHT1] = p1_s[1];
    gdb0_d[GDB0_DOWN1]  = p1_s[2];
    gdb0_d[GDB0_UP1]    = p1_s[3];
    gdb0_d[GDB0_LEFT2]  = p2_s[0];
    gdb0_d[GDB0_RIGHT2] = p2_s[1];
    gdb0_d[GDB0_DOWN2]  = p2_s[2];
    gdb0_d[GDB0_UP2]    = p2_s[3];
    start_d = {stable_vec[RawStart2], stable_vec[RawStart1]};
  end

  // Coin FSM next state; take marks a credit leaving the queue.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pending_q != '0) begin
          take    = 1'b1;
          timer_d = '0;
          state_d = PULSE;
        end
      end
      PULSE: begin
        if (timer_q == PulseLast) begin
          timer_d = '0;
          state_d = GAP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      GAP: begin
        if (timer_q == GapLast) begin
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Credit queue: simultaneous add and take cancel; adds beyond the max are dropped.
  always_comb begin
    pending_d = pending_q;
    if (coin_rise && !take) begin
      if (pending_q != PENDING_MAX) pending_d = pending_q + 1'b1;
    end else if (take && !coin_rise) begin
      pending_d = pending_q - 1'b1;
    end
  end

  // All top-level state with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      gdb0_q    <= '0;
      start_q   <= '0;
      state_q   <= IDLE;
      timer_q   <= '0;
      pending_q <= '0;
    end else begin
      gdb0_q    <= gdb0_d;
      start_q   <= start_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
    end
  end

  // gdb1 assembly; unused bits tied low.
  always_comb begin
    gdb1              = '0;
    gdb1[GDB1_START1] = start_q[0];
    gdb1[GDB1_START2] = start_q[1];
    gdb1[GDB1_COIN]   = (state_q == PULSE);
  end

  assign gdb0         = gdb0_q;
  assign coin_pending = pending_q;

endmodule

// File: tb/tb_maze_input_cond.sv
// Randomised self-checking bench for maze_input_cond with a window-based reference model.
module tb_maze_input_cond;

  localparam int unsigned DEB = 4;
  localparam int unsigned TP  = 8;
  localparam int unsigned TG  = 4;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] p1_dir = '0;
  logic [3:0] p2_dir = '0;
  logic       coin_raw = 1'b0;
  logic       start1_raw = 1'b0;
  logic       start2_raw = 1'b0;
  logic [7:0] gdb0, gdb1;
  logic [1:0] coin_pending;

  int checks = 0;
  int errors = 0;

  maze_input_cond #(
    .DEB_CYCLES(DEB),
    .COIN_PULSE(TP),
    .COIN_GAP  (TG)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .p1_dir      (p1_dir),
    .p2_dir      (p2_dir),
    .coin_raw    (coin_raw),
    .start1_raw  (start1_raw),
    .start2_raw  (start2_raw),
    .gdb0        (gdb0),
    .gdb1        (gdb1),
    .coin_pending(coin_pending)
  );

  always #5 clk_sys = ~clk_sys;

  // Reference model: a bit changes once its last DEB samples all disagree with it;
  // credits are pulsed TP cycles long, at most one start every TP+TG+1 edges.
  logic [10:0]    m_stable = '0;
  logic [DEB-1:0] m_hist[11];
  int unsigned    m_seen[11];
  logic [7:0]     exp_gdb0 = '0;
  logic [7:0]     exp_gdb1 = '0;
  logic [1:0]     exp_pend = '0;
  int unsigned    ecnt = 0;
  int unsigned    next_start = 0;
  int unsigned    pulse_start = 0;
  bit             pulse_valid = 0;
  bit             m_rose = 0;
  int unsigned    m_accepted = 0;

  function automatic logic [3:0] supp(input logic [3:0] d);
    logic [3:0] r;
    r = d;
    if (d[3] && d[2]) r[3:2] = 2'b00;
    if (d[1] && d[0]) r[1:0] = 2'b00;
    return r;
  endfunction

  task automatic model_edge();
    logic [10:0] raw, pre;
    bit inc, dec, coin;
    raw = {start2_raw, start1_raw, coin_raw, p2_dir, p1_dir};
    if (reset) begin
      for (int b = 0; b < 11; b++) begin
        m_hist[b] = '0;
        m_seen[b] = 0;
      end
      m_stable    = '0;
      m_rose      = 0;
      exp_gdb0    = '0;
      exp_gdb1    = '0;
      exp_pend    = '0;
      pulse_valid = 0;
      next_start  = ecnt + 1;
    end else begin
      pre      = m_stable;
      exp_gdb0 = {supp(pre[7:4]), supp(pre[3:0])};
      inc      = m_rose;
      m_rose   = 0;
      for (int b = 0; b < 11; b++) begin
        m_hist[b] = {m_hist[b][DEB-2:0], raw[b]};
        if (m_seen[b] < DEB) m_seen[b]++;
        if (m_seen[b] == DEB && m_hist[b] == {DEB{~pre[b]}}) begin
          m_stable[b] = raw[b];
          if (b == 8 && raw[b]) m_rose = 1;
        end
      end
      dec = (ecnt >= next_start) && (exp_pend != 0);
      if (dec) begin
        pulse_valid = 1;
        pulse_start = ecnt;
        next_start  = ecnt + TP + TG + 1;
      end
      if (inc && !dec) begin
        if (exp_pend < 3) begin
          exp_pend++;
          m_accepted++;
        end
      end else if (inc && dec) begin
        m_accepted++;
      end else if (dec) begin
        exp_pend--;
      end
      coin     = pulse_valid && ecnt >= pulse_start && ecnt < pulse_start + TP;
      exp_gdb1 = {4'b0, coin, 1'b0, pre[10], pre[9]};
    end
    ecnt++;
  endtask

  initial begin
    forever begin
      @(posedge clk_sys);
      model_edge();
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, errors %0d", errors);
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    p1_dir = 4'hF; p2_dir = 4'hF; coin_raw = 1; start1_raw = 1; start2_raw = 1;
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      if (i == 2) reset = 0;
      checks++;
      if (gdb0 !== 8'h00) begin errors++; $display("FAIL reset_gdb0 cyc %0d: got %h want 00", i, gdb0); end
      checks++;
      if (gdb1 !== 8'h00) begin errors++; $display("FAIL reset_gdb1 cyc %0d: got %h want 00", i, gdb1); end
      checks++;
      if (coin_pending !== 2'd0) begin errors++; $display("FAIL reset_pend cyc %0d: got %0d want 0", i, coin_pending); end
    end
    p1_dir = 0; p2_dir = 0; coin_raw = 0; start1_raw = 0; start2_raw = 0;
    repeat (6) @(negedge clk_sys);
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 9; i++) begin
      p1_dir = (i < 3) ? 4'b0001 : 4'b0000;
      @(negedge clk_sys);
      checks++;
      if (gdb0 !== 8'h00) begin errors++; $display("FAIL glitch_reject cyc %0d: got %h want 00", i, gdb0); end
    end
    for (int i = 0; i < 12; i++) begin
      p1_dir = (i < 6) ? 4'b0001 : 4'b0000;
      @(negedge clk_sys);
      checks++;
      if (gdb0 !== exp_gdb0) begin errors++; $display("FAIL glitch_hold cyc %0d: got %h want %h", i, gdb0, exp_gdb0); end
      if (i == 5) begin
        checks++;
        if (gdb0 !== 8'h01) begin errors++; $display("FAIL glitch_set: got %h want 01", gdb0); end
      end
    end
    checks++;
    if (gdb0 !== 8'h00) begin errors++; $display("FAIL glitch_release: got %h want 00", gdb0); end
  endtask

  task automatic test_opposing();
    p1_dir = 4'b1100;
    repeat (6) @(negedge clk_sys);
    checks++;
    if (gdb0[3:2] !== 2'b00 || gdb0 !== exp_gdb0) begin
      errors++; $display("FAIL opp_p1_ud: got %h want %h", gdb0, exp_gdb0);
    end
    p2_dir = 4'b1010;
    repeat (6) @(negedge clk_sys);
    checks++;
    if (gdb0 !== 8'hA0) begin errors++; $display("FAIL opp_p2_ur: got %h want a0", gdb0); end
    p2_dir = 4'b0011;
    repeat (6) @(negedge clk_sys);
    checks++;
    if (gdb0[5:4] !== 2'b00 || gdb0 !== exp_gdb0) begin
      errors++; $display("FAIL opp_p2_rl: got %h want %h", gdb0, exp_gdb0);
    end
    p1_dir = 0; p2_dir = 0;
    repeat (6) @(negedge clk_sys);
  endtask

  task automatic test_single_credit();
    int pulses = 0, run = 0, bad = 0;
    for (int i = 0; i < 90; i++) begin
      coin_raw = (i < 50);
      @(negedge clk_sys);
      if (gdb1 !== exp_gdb1 || coin_pending !== exp_pend) bad++;
      if (gdb1[3]) run++;
      else if (run != 0) begin
        pulses++;
        checks++;
        if (run != TP) begin errors++; $display("FAIL single_width: got %0d want %0d", run, TP); end
        run = 0;
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL single_model: %0d cycles differ, want 0", bad); end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL single_count: got %0d want 1", pulses); end
    checks++;
    if (coin_pending !== 2'd0) begin errors++; $display("FAIL single_pend: got %0d want 0", coin_pending); end
  endtask

  task automatic test_queue();
    int pulses = 0, run = 0, low = 0, bad = 0, peak = 0;
    int unsigned acc0;
    bit seen_pulse = 0;
    acc0 = m_accepted;
    for (int i = 0; i < 12 * 8 + 200; i++) begin
      coin_raw = (i < 12 * 8) && ((i % 8) < 4);
      @(negedge clk_sys);
      if (gdb1 !== exp_gdb1 || coin_pending !== exp_pend) bad++;
      if (int'(coin_pending) > peak) peak = int'(coin_pending);
      if (gdb1[3]) begin
        if (run == 0 && seen_pulse) begin
          checks++;
          if (low < TG + 1) begin errors++; $display("FAIL queue_gap: got %0d want >= %0d", low, TG + 1); end
        end
        run++;
        low = 0;
      end else begin
        if (run != 0) begin
          pulses++;
          seen_pulse = 1;
          checks++;
          if (run != TP) begin errors++; $display("FAIL queue_width: got %0d want %0d", run, TP); end
        end
        run = 0;
        low++;
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL queue_model: %0d cycles differ, want 0", bad); end
    checks++;
    if (peak != 3) begin errors++; $display("FAIL queue_peak: got %0d want 3", peak); end
    checks++;
    if (pulses != int'(m_accepted - acc0)) begin
      errors++; $display("FAIL queue_count: got %0d want %0d", pulses, m_accepted - acc0);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    for (int i = 0; i < 400; i++) begin
      coin_raw = ((i % 8) < 4);
      @(negedge clk_sys);
      if (gdb1[3] && coin_pending == 2'd2) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rmid_setup: got no pulse with pending 2, want one"); end
    reset = 1; coin_raw = 0;
    @(negedge clk_sys);
    checks++;
    if (gdb1 !== 8'h00) begin errors++; $display("FAIL rmid_gdb1: got %h want 00", gdb1); end
    checks++;
    if (coin_pending !== 2'd0) begin errors++; $display("FAIL rmid_pend: got %0d want 0", coin_pending); end
    reset = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_sys);
      checks++;
      if (gdb1[3] !== 1'b0) begin errors++; $display("FAIL rmid_nopulse cyc %0d: got %b want 0", i, gdb1[3]); end
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(5) == 0) p1_dir = 4'($urandom);
      if ($urandom_range(5) == 0) p2_dir = 4'($urandom);
      if ($urandom_range(4) == 0) coin_raw = ~coin_raw;
      if ($urandom_range(6) == 0) start1_raw = 1'($urandom);
      if ($urandom_range(6) == 0) start2_raw = 1'($urandom);
      reset = ($urandom_range(399) == 0);
      @(negedge clk_sys);
      checks++;
      if (gdb0 !== exp_gdb0 || gdb1 !== exp_gdb1 || coin_pending !== exp_pend) begin
        bad++;
        errors++;
        if (bad <= 5)
          $display("FAIL random cyc %0d: got %h/%h/%0d want %h/%h/%0d", i, gdb0, gdb1,
                   coin_pending, exp_gdb0, exp_gdb1, exp_pend);
      end
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_opposing();
    test_single_credit();
    test_queue();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
